// File: rtl/cdiv16.sv
// Streaming complex divider p = a*conj(b)/|b|^2 (restoring radix-2, real/imag in parallel); build option CDIV16_DBZ_FLAG_EN adds out_dbz.
// Latency: out_tvalid rises DATA_WIDTH+3 edges after the accept edge, counting that edge; one sample per DATA_WIDTH+4 cycles.
// Backpressure: one sample in flight; in_tready only in IDLE; the result is held in DONE until out_tready.
module cdiv16 #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    input  logic [2*DATA_WIDTH-1:0] adata,
    input  logic [2*DATA_WIDTH-1:0] bdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready,
    output logic [2*DATA_WIDTH-1:0] pdata
`ifdef CDIV16_DBZ_FLAG_EN
    ,
    output logic                    out_dbz
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W;          // product width
    localparam int NW = 2 * W + 1;      // numerator / denominator width
    localparam int RW = NW + W;         // remainder width: holds den << (W-1) and |num| << FRAC_BITS
    localparam int CW = $clog2(W);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, PREP, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic                 tlast_r;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic                 neg_re, neg_im, ovf_re, ovf_im, dbz;
    logic [RW-1:0]        rem_re, rem_im, dsh;
    logic [W-1:0]         q_re, q_im;
    logic [CW-1:0]        cnt;

    // PREP-stage arithmetic: numerators, denominator, magnitudes and overflow test
    logic signed [NW-1:0] num_re, num_im;
    logic signed [PW-1:0] sq_re, sq_im;
    logic [NW-1:0]        den, mag_re, mag_im;
    logic [RW-1:0]        dvd_re, dvd_im, den_sh;

    assign num_re = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
    assign num_im = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
    assign sq_re  = PW'(b_re) * PW'(b_re);
    assign sq_im  = PW'(b_im) * PW'(b_im);
    // Both squares are non-negative, so zero extension is exact; (-2^(W-1))^2 * 2 = 2^(2W-1) fits NW bits
    assign den    = {1'b0, sq_re} + {1'b0, sq_im};
    assign mag_re = num_re[NW-1] ? -num_re : num_re;
    assign mag_im = num_im[NW-1] ? -num_im : num_im;
    assign dvd_re = {{W{1'b0}}, mag_re} << FRAC_BITS;
    assign dvd_im = {{W{1'b0}}, mag_im} << FRAC_BITS;
    assign den_sh = {{W{1'b0}}, den} << (W - 1);

    // One restoring step per DIV cycle; dsh walks den<<cnt down by one bit each cycle
    logic          ge_re, ge_im;
    logic [RW-1:0] rem_re_nxt, rem_im_nxt;
    logic [W-1:0]  q_re_nxt, q_im_nxt;

    assign ge_re      = rem_re >= dsh;
    assign ge_im      = rem_im >= dsh;
    assign rem_re_nxt = ge_re ? rem_re - dsh : rem_re;
    assign rem_im_nxt = ge_im ? rem_im - dsh : rem_im;
    assign q_re_nxt   = {q_re[W-2:0], ge_re};
    assign q_im_nxt   = {q_im[W-2:0], ge_im};

    // Sign, saturation and divide-by-zero handling for one component
    function automatic logic [W-1:0] finish_comp(
        input logic [W-1:0]        q,
        input logic                neg,
        input logic                ovf,
        input logic                dz,
        input logic signed [W-1:0] a_comp
    );
        logic [W-1:0] r;
        if (dz) begin
            if (a_comp > 0)      r = MAX_POS;
            else if (a_comp < 0) r = MAX_NEG;
            else                 r = '0;
        end else if (ovf) begin
            r = neg ? MAX_NEG : MAX_POS;
        end else begin
            r = neg ? -q : q;
        end
        return r;
    endfunction

    logic [W-1:0] res_re, res_im;

    assign res_re = finish_comp(q_re_nxt, neg_re, ovf_re, dbz, a_re);
    assign res_im = finish_comp(q_im_nxt, neg_im, ovf_im, dbz, a_im);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt  = state;
        in_tready  = 1'b0;
        out_tvalid = 1'b0;
        case (state)
            IDLE: begin
                in_tready = 1'b1;
                if (in_tvalid) state_nxt = MUL;
            end
            MUL:  state_nxt = PREP;
            PREP: state_nxt = DIV;
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: begin
                out_tvalid = 1'b1;
                if (out_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, products, divider setup, iteration and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            a_re      <= '0;
            a_im      <= '0;
            b_re      <= '0;
            b_im      <= '0;
            tlast_r   <= 1'b0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ir      <= '0;
            p_ri      <= '0;
            neg_re    <= 1'b0;
            neg_im    <= 1'b0;
            ovf_re    <= 1'b0;
            ovf_im    <= 1'b0;
            dbz       <= 1'b0;
            rem_re    <= '0;
            rem_im    <= '0;
            dsh       <= '0;
            q_re      <= '0;
            q_im      <= '0;
            cnt       <= '0;
            pdata     <= '0;
            out_tlast <= 1'b0;
`ifdef CDIV16_DBZ_FLAG_EN
            out_dbz   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_tvalid) begin
                        a_re    <= adata[2*W-1:W];
                        a_im    <= adata[W-1:0];
                        b_re    <= bdata[2*W-1:W];
                        b_im    <= bdata[W-1:0];
                        tlast_r <= in_tlast;
                    end
                end
                MUL: begin
                    p_rr <= PW'(a_re) * PW'(b_re);
                    p_ii <= PW'(a_im) * PW'(b_im);
                    p_ir <= PW'(a_im) * PW'(b_re);
                    p_ri <= PW'(a_re) * PW'(b_im);
                end
                PREP: begin
                    neg_re <= num_re[NW-1];
                    neg_im <= num_im[NW-1];
                    rem_re <= dvd_re;
                    rem_im <= dvd_im;
                    ovf_re <= dvd_re >= den_sh;
                    ovf_im <= dvd_im >= den_sh;
                    dbz    <= den == '0;
                    dsh    <= den_sh;
                    q_re   <= '0;
                    q_im   <= '0;
                    cnt    <= CW'(W - 1);
                end
                DIV: begin
                    rem_re <= rem_re_nxt;
                    rem_im <= rem_im_nxt;
                    q_re   <= q_re_nxt;
                    q_im   <= q_im_nxt;
                    dsh    <= dsh >> 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        pdata     <= {res_re, res_im};
                        out_tlast <= tlast_r;
`ifdef CDIV16_DBZ_FLAG_EN
                        out_dbz   <= dbz;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdiv16.sv
`timescale 1ns/1ps
module tb_cdiv16;
    localparam int W  = 16;
    localparam int F  = 14;
    localparam int ND = 11;
    localparam logic [W-1:0] MAXV = 16'h7FFF;
    localparam logic [W-1:0] MINV = 16'h8000;

    logic         clk = 1'b0;
    logic         reset, in_tvalid, in_tlast, in_tready;
    logic         out_tvalid, out_tlast, out_tready;
    logic [31:0]  adata, bdata, pdata;
`ifdef CDIV16_DBZ_FLAG_EN
    logic         out_dbz;
`endif

    cdiv16 #(.DATA_WIDTH(W), .FRAC_BITS(F)) dut (
        .clk(clk), .reset(reset),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .adata(adata), .bdata(bdata),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .pdata(pdata)
`ifdef CDIV16_DBZ_FLAG_EN
        , .out_dbz(out_dbz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] p;
        logic        last;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Directed operands and hand-derived quotients
    localparam logic [31:0] DA [ND] = '{32'h4000_0000, 32'h4000_0000, 32'h2000_2000, 32'h4000_0000,
                                        32'hC000_0000, 32'h0064_FFFB, 32'h0000_0000, 32'h8000_8000,
                                        32'hE000_1000, 32'hFFFF_0000, 32'h0001_0000};
    localparam logic [31:0] DB [ND] = '{32'h4000_0000, 32'h0000_4000, 32'h2000_E000, 32'h1000_0000,
                                        32'h1000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_8000,
                                        32'h4000_0000, 32'h0003_0000, 32'h0003_0000};
    localparam logic [31:0] DP [ND] = '{32'h4000_0000, 32'h0000_C000, 32'h0000_4000, 32'h7FFF_0000,
                                        32'h8000_0000, 32'h7FFF_8000, 32'h0000_0000, 32'h4000_0000,
                                        32'hE000_1000, 32'hEAAB_0000, 32'h1555_0000};

    function automatic logic [W-1:0] model_comp(input longint num, input longint den, input longint a_comp);
        longint mag, q;
        if (den == 0) begin
            if (a_comp > 0) return MAXV;
            if (a_comp < 0) return MINV;
            return '0;
        end
        mag = (num < 0) ? -num : num;
        q   = (mag << F) / den;
        if (q >= (longint'(1) << (W - 1))) return (num < 0) ? MINV : MAXV;
        return (num < 0) ? W'(-q) : W'(q);
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic last);
        longint ar, ai, br, bi, nr, ni, den;
        exp_t   e;
        ar  = longint'($signed(a[31:16]));
        ai  = longint'($signed(a[15:0]));
        br  = longint'($signed(b[31:16]));
        bi  = longint'($signed(b[15:0]));
        nr  = ar * br + ai * bi;
        ni  = ai * br - ar * bi;
        den = br * br + bi * bi;
        e.p    = {model_comp(nr, den, ar), model_comp(ni, den, ai)};
        e.last = last;
        e.dz   = (den == 0);
        return e;
    endfunction

    // Present one sample and hold it until accepted; expected result queued at the accept edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                        input bit push, output time t_acc);
        int i;
        adata     = a;
        bdata     = b;
        in_tlast  = last;
        in_tvalid = 1'b1;
        i = 0;
        while (!in_tready && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        t_acc = 0;
        if (!in_tready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_tready stayed %b, want 1", in_tready);
        end else begin
            @(posedge clk);
            t_acc = $time;
            if (push) sb.push_back(model(a, b, last));
            #1;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        adata      = '0;
        bdata      = '0;
        out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_tready !== 1'b1)  begin n_err++; $display("FAIL reset_in_tready: got %b want 1", in_tready); end
        n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_out_tvalid: got %b want 0", out_tvalid); end
        n_cmp++; if (out_tlast !== 1'b0)  begin n_err++; $display("FAIL reset_out_tlast: got %b want 0", out_tlast); end
        n_cmp++; if (pdata !== 32'h0)     begin n_err++; $display("FAIL reset_pdata: got %h want 0", pdata); end
`ifdef CDIV16_DBZ_FLAG_EN
        n_cmp++; if (out_dbz !== 1'b0)    begin n_err++; $display("FAIL reset_out_dbz: got %b want 0", out_dbz); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_directed();
        time  t;
        int   lat;
        exp_t e;
        out_tready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            send(DA[i], DB[i], (i % 2) == 1, 1'b1, t);
            lat = 1;
            while (!out_tvalid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++;
            if (lat != W + 3) begin n_err++; $display("FAIL latency[%0d]: got %0d edges want %0d", i, lat, W + 3); end
            n_cmp++;
            if (pdata !== DP[i]) begin n_err++; $display("FAIL directed_pdata[%0d]: got %h want %h", i, pdata, DP[i]); end
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL directed_sb[%0d]: queue empty, want 1 entry", i);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (out_tlast !== e.last) begin n_err++; $display("FAIL directed_tlast[%0d]: got %b want %b", i, out_tlast, e.last); end
`ifdef CDIV16_DBZ_FLAG_EN
                n_cmp++;
                if (out_dbz !== e.dz) begin n_err++; $display("FAIL directed_dbz[%0d]: got %b want %b", i, out_dbz, e.dz); end
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                time t;
                for (int i = 0; i < 8; i++)
                    send($urandom(), $urandom(), (i == 3) || (i == 7), 1'b1, t);
            end
            begin
                int          k = 0;
                int          cyc = 0;
                bit          held = 1'b0;
                logic [31:0] hp;
                logic        hl;
                exp_t        e;
                while (k < 8 && cyc < 3000) begin
                    out_tready = 1'($urandom_range(0, 1));
                    if (out_tvalid) begin
                        if (held) begin
                            n_cmp++;
                            if (pdata !== hp || out_tlast !== hl) begin
                                n_err++;
                                $display("FAIL stall_hold[%0d]: got %h/%b want %h/%b", k, pdata, out_tlast, hp, hl);
                            end
                        end
                        if (out_tready) begin
                            if (sb.size() == 0) begin
                                n_cmp++; n_err++;
                                $display("FAIL b2b_sb[%0d]: queue empty, want 1 entry", k);
                            end else begin
                                e = sb.pop_front();
                                n_cmp++;
                                if (pdata !== e.p) begin n_err++; $display("FAIL b2b_pdata[%0d]: got %h want %h", k, pdata, e.p); end
                                n_cmp++;
                                if (out_tlast !== e.last) begin n_err++; $display("FAIL b2b_tlast[%0d]: got %b want %b", k, out_tlast, e.last); end
                            end
                            held = 1'b0;
                            k++;
                        end else begin
                            held = 1'b1;
                            hp   = pdata;
                            hl   = out_tlast;
                        end
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                n_cmp++;
                if (k != 8) begin n_err++; $display("FAIL b2b_count: got %0d outputs want 8", k); end
                out_tready = 1'b1;
            end
        join
    endtask

    task automatic test_throughput();
        time  ta [3];
        out_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    send({16'(i * 1000 + 7), 16'h0100}, {16'h2000, 16'(i * 300)}, 1'b0, 1'b1, ta[i]);
            end
            begin
                int   k = 0;
                int   cyc = 0;
                exp_t e;
                while (k < 3 && cyc < 500) begin
                    if (out_tvalid && sb.size() != 0) begin
                        e = sb.pop_front();
                        n_cmp++;
                        if (pdata !== e.p) begin n_err++; $display("FAIL tput_pdata[%0d]: got %h want %h", k, pdata, e.p); end
                        k++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (ta[i] - ta[i-1] != (W + 4) * 10) begin
                n_err++;
                $display("FAIL tput_period[%0d]: got %0t want %0d", i, ta[i] - ta[i-1], (W + 4) * 10);
            end
        end
    endtask

    task automatic test_reset_div();
        time  t;
        bit   seen;
        int   lat;
        exp_t e;
        out_tready = 1'b1;
        send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_div_tvalid: got %b want 0", out_tvalid); end
        n_cmp++; if (in_tready !== 1'b1)  begin n_err++; $display("FAIL rst_div_tready: got %b want 1", in_tready); end
        seen = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (out_tvalid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL rst_div_ghost: got an output want none"); end
        send(32'hE000_1000, 32'h4000_0000, 1'b0, 1'b1, t);
        lat = 1;
        while (!out_tvalid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rst_div_sb: queue empty, want 1 entry");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (pdata !== e.p) begin n_err++; $display("FAIL rst_div_pdata: got %h want %h", pdata, e.p); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_throughput();
        test_reset_div();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d leftover want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
